// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives all 16 {x,y,w,z} vectors into a 4-input function,
// captures its output per vector and compares the table against an expected mask.
module truth_table_sweeper #(
  parameter int SETTLE = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [15:0] i_expected,
  input  logic        i_f_in,
  output logic [3:0]  o_vec,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_table,
  output logic [15:0] o_mismatch,
  output logic        o_pass,
  output logic [3:0]  o_first_err,
  output logic        o_err_valid
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

  state_t      r_state, w_state_next;
  logic [3:0]  r_vec, w_vec_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic [3:0]  r_first_err, w_first_err_next;
  logic [15:0] r_exp, w_exp_next;
  logic [15:0] r_table, w_table_next;
  logic [15:0] r_mismatch, w_mismatch_next;
  logic        r_busy, w_busy_next;
  logic        r_done, w_done_next;
  logic        r_pass, w_pass_next;
  logic        r_err_valid, w_err_valid_next;
  logic        w_miss_bit;

  assign w_miss_bit = i_f_in ^ r_exp[r_vec];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_vec       <= '0;
      r_cnt       <= '0;
      r_first_err <= '0;
      r_exp       <= '0;
      r_table     <= '0;
      r_mismatch  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_vec       <= w_vec_next;
      r_cnt       <= w_cnt_next;
      r_first_err <= w_first_err_next;
      r_exp       <= w_exp_next;
      r_table     <= w_table_next;
      r_mismatch  <= w_mismatch_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_pass      <= w_pass_next;
      r_err_valid <= w_err_valid_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_vec_next       = r_vec;
    w_cnt_next       = r_cnt;
    w_first_err_next = r_first_err;
    w_exp_next       = r_exp;
    w_table_next     = r_table;
    w_mismatch_next  = r_mismatch;
    w_busy_next      = r_busy;
    w_done_next      = 1'b0;
    w_pass_next      = r_pass;
    w_err_valid_next = r_err_valid;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_exp_next       = i_expected;
          w_table_next     = '0;
          w_mismatch_next  = '0;
          w_pass_next      = 1'b0;
          w_err_valid_next = 1'b0;
          w_first_err_next = '0;
          w_vec_next       = '0;
          w_cnt_next       = '0;
          w_busy_next      = 1'b1;
          w_state_next     = S_DRIVE;
        end
      end
      S_DRIVE: begin
        w_cnt_next = r_cnt + 4'd1;
        if (r_cnt == 4'(SETTLE - 1)) w_state_next = S_SAMPLE;
      end
      S_SAMPLE: begin
        w_table_next[r_vec]    = i_f_in;
        w_mismatch_next[r_vec] = w_miss_bit;
        if (w_miss_bit && !r_err_valid) begin
          w_first_err_next = r_vec;
          w_err_valid_next = 1'b1;
        end
        if (r_vec == 4'd15) begin
          // pass must include the bit written on this final edge
          w_pass_next  = (w_mismatch_next == 16'h0000);
          w_busy_next  = 1'b0;
          w_done_next  = 1'b1;
          w_state_next = S_DONE;
        end else begin
          w_vec_next   = r_vec + 4'd1;
          w_cnt_next   = '0;
          w_state_next = S_DRIVE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign o_vec       = r_vec;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_table     = r_table;
  assign o_mismatch  = r_mismatch;
  assign o_pass      = r_pass;
  assign o_first_err = r_first_err;
  assign o_err_valid = r_err_valid;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: two instances (SETTLE=1 and SETTLE=3)
// with hand-computed truth tables, timing, restart and abort scenarios.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b;
  logic [15:0] exp_in;
  logic        fsel;
  logic        sel;

  logic [3:0]  vec_a, vec_b, first_err_a, first_err_b;
  logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b, ev_a, ev_b;
  logic [15:0] table_a, table_b, mism_a, mism_b;
  logic        f_a, f_b;

  int n_vec = 0;
  int n_err = 0;

  int   res_cycles, res_busy, res_vec_bad, res_extra;
  logic res_ev_before;

  always #5 clk = ~clk;

  // Function under test: (Y|W)&(X|~Y|~W)&(~X|~Y|Z), vec = {x,y,w,z}
  function automatic logic golden_f(input logic [3:0] v);
    logic x, y, w, z;
    {x, y, w, z} = v;
    return (y | w) & (x | ~y | ~w) & (~x | ~y | z);
  endfunction

  assign f_a = fsel ? vec_a[3] : golden_f(vec_a);
  assign f_b = vec_b[3];

  truth_table_sweeper #(.SETTLE(1)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_expected(exp_in), .i_f_in(f_a),
    .o_vec(vec_a), .o_busy(busy_a), .o_done(done_a), .o_table(table_a),
    .o_mismatch(mism_a), .o_pass(pass_a), .o_first_err(first_err_a), .o_err_valid(ev_a)
  );

  truth_table_sweeper #(.SETTLE(3)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_expected(exp_in), .i_f_in(f_b),
    .o_vec(vec_b), .o_busy(busy_b), .o_done(done_b), .o_table(table_b),
    .o_mismatch(mism_b), .o_pass(pass_b), .o_first_err(first_err_b), .o_err_valid(ev_b)
  );

  logic [3:0]  m_vec, m_first_err;
  logic        m_busy, m_done, m_pass, m_ev;
  logic [15:0] m_table, m_mism;
  assign m_vec       = sel ? vec_b : vec_a;
  assign m_first_err = sel ? first_err_b : first_err_a;
  assign m_busy      = sel ? busy_b : busy_a;
  assign m_done      = sel ? done_b : done_a;
  assign m_pass      = sel ? pass_b : pass_a;
  assign m_ev        = sel ? ev_b : ev_a;
  assign m_table     = sel ? table_b : table_a;
  assign m_mism      = sel ? mism_b : mism_a;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Starts a sweep on the selected instance and follows it to done.
  task automatic run_sweep(input logic use_b, input logic [15:0] e, input int repulse);
    int         n;
    logic       seen;
    logic       rep_done;
    logic [3:0] prev;
    sel = use_b;
    @(negedge clk);
    exp_in = e;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    exp_in  = ~e;
    n = 1; seen = 1'b0; rep_done = 1'b0; prev = 4'd0;
    res_busy = 0; res_vec_bad = 0; res_ev_before = 1'b0; res_cycles = 0;
    while (!seen && n <= 400) begin
      if (m_vec != prev && m_vec != prev + 4'd1) res_vec_bad++;
      prev = m_vec;
      if (m_busy) res_busy++;
      if (m_done) begin
        seen = 1'b1;
        res_cycles = n;
      end else begin
        res_ev_before = m_ev;
        if (repulse >= 0 && !rep_done && m_vec == 4'(repulse)) begin
          if (use_b) start_b = 1'b1; else start_a = 1'b1;
          rep_done = 1'b1;
        end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        n++;
      end
    end
    check_val("sweep_timeout", {63'd0, seen}, 64'd1);
    res_extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (m_done) res_extra++;
    end
  endtask

  task automatic check_results(input string tag, input logic [15:0] tbl, input logic [15:0] mm,
                               input logic ps, input logic ev, input logic [3:0] fe);
    check_val({tag, "_table"}, 64'(m_table), 64'(tbl));
    check_val({tag, "_mismatch"}, 64'(m_mism), 64'(mm));
    check_val({tag, "_pass"}, 64'(m_pass), 64'(ps));
    check_val({tag, "_err_valid"}, 64'(m_ev), 64'(ev));
    if (ev) check_val({tag, "_first_err"}, 64'(m_first_err), 64'(fe));
    check_val({tag, "_vec_end"}, 64'(m_vec), 64'd15);
    check_val({tag, "_busy_end"}, 64'(m_busy), 64'd0);
  endtask

  function automatic logic [63:0] outs_a();
    return 64'({vec_a, busy_a, done_a, table_a, mism_a, pass_a, first_err_a, ev_a});
  endfunction

  initial begin
    int n;
    int dcount;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; exp_in = 16'h0; fsel = 1'b0; sel = 1'b0;
    repeat (2) @(negedge clk);
    check_val("reset_outs_a", outs_a(), 64'd0);
    check_val("reset_outs_b",
              64'({vec_b, busy_b, done_b, table_b, mism_b, pass_b, first_err_b, ev_b}), 64'd0);
    rst_n = 1'b1;

    // Golden sweep
    run_sweep(1'b0, 16'hAC3C, -1);
    check_val("golden_done_cycle", 64'(res_cycles), 64'd33);
    check_val("golden_busy_cycles", 64'(res_busy), 64'd32);
    check_val("golden_vec_seq", 64'(res_vec_bad), 64'd0);
    check_val("golden_extra_done", 64'(res_extra), 64'd0);
    check_results("golden", 16'hAC3C, 16'h0000, 1'b1, 1'b0, 4'd0);

    // Single error at vector 0
    run_sweep(1'b0, 16'hAC3D, -1);
    check_results("err0", 16'hAC3C, 16'h0001, 1'b0, 1'b1, 4'd0);

    // Error only at the last vector
    run_sweep(1'b0, 16'h2C3C, -1);
    check_val("err15_ev_before_final", 64'(res_ev_before), 64'd0);
    check_val("err15_done_cycle", 64'(res_cycles), 64'd33);
    check_results("err15", 16'hAC3C, 16'h8000, 1'b0, 1'b1, 4'd15);

    // Trivial function f = x
    fsel = 1'b1;
    run_sweep(1'b0, 16'hFF00, -1);
    check_results("trivial", 16'hFF00, 16'h0000, 1'b1, 1'b0, 4'd0);

    // Trivial function with SETTLE=3
    run_sweep(1'b1, 16'hFF00, -1);
    check_val("settle3_done_cycle", 64'(res_cycles), 64'd65);
    check_val("settle3_busy_cycles", 64'(res_busy), 64'd64);
    check_val("settle3_vec_seq", 64'(res_vec_bad), 64'd0);
    check_results("settle3", 16'hFF00, 16'h0000, 1'b1, 1'b0, 4'd0);

    // Start re-pulsed while busy at vec=5
    fsel = 1'b0;
    run_sweep(1'b0, 16'hAC3C, 5);
    check_val("restart_vec_seq", 64'(res_vec_bad), 64'd0);
    check_val("restart_done_cycle", 64'(res_cycles), 64'd33);
    check_val("restart_extra_done", 64'(res_extra), 64'd0);
    check_results("restart", 16'hAC3C, 16'h0000, 1'b1, 1'b0, 4'd0);

    // Reset mid-sweep at vec=7
    sel = 1'b0;
    @(negedge clk);
    exp_in = 16'hAC3D;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n = 0;
    while (vec_a != 4'd7 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("abort_reach_vec7", 64'(vec_a), 64'd7);
    rst_n = 1'b0;
    #1;
    check_val("abort_async_clear", outs_a(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_a) dcount++;
    end
    check_val("abort_no_done", 64'(dcount), 64'd0);
    check_val("abort_idle_outs", outs_a(), 64'd0);

    run_sweep(1'b0, 16'hAC3C, -1);
    check_val("after_abort_vec_seq", 64'(res_vec_bad), 64'd0);
    check_val("after_abort_done_cycle", 64'(res_cycles), 64'd33);
    check_results("after_abort", 16'hAC3C, 16'h0000, 1'b1, 1'b0, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
